main_seq: RTL
=============

Name: main_seq

Overview:
- Parametrised successor to the rectilinearizer top-level mode FSM.
- Sequences NUM_STAGES processing stages (auto detection, manual corner set, warp, ...) from the view-finder idle mode.
- Each stage gets a one-cycle start pulse, a wait-for-done phase and a user-review hold phase.
- Adds enter-button edge detection, a per-stage bypass mask, abort from wait, and an optional watchdog timeout.

Parameters:
- NUM_STAGES, 3, number of sequenced stages (1..8).
- TIMEOUT_CYCLES, 27000000, WAIT-phase watchdog limit in clk cycles (used only with the macro).
- SW, $clog2(NUM_STAGES) with minimum 1, stage index width (derived; do not override).

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- button_enter  input  1  debounced, synchronous enter button level.
- switch  input  1  direction select: 1 = forwards, 0 = backwards.
- stage_bypass  input  NUM_STAGES  1 = skip stage when advancing.
- stage_done  input  NUM_STAGES  per-stage completion pulse or level.
- phase  output  2  0 IDLE (view finder), 1 START, 2 WAIT, 3 HOLD.
- stage_idx  output  SW  current stage; 0 in IDLE.
- stage_start  output  NUM_STAGES  one-hot start pulse, bit stage_idx, high only in START.
- busy  output  1  high in START or WAIT.
- timeout_err  output  1  sticky watchdog flag.

Behaviour:
- Reset (async, any time, including mid-operation): phase=IDLE, stage_idx=0, stage_start=0, busy=0, timeout_err=0, press register=0. Outputs drop on reset assertion without waiting for a clock edge.
- Edge detect: press = button_enter & ~button_enter_q (registered). fwd = press & switch; bwd = press & ~switch. A held button yields exactly one event.
- All outputs decode combinationally from registered phase/stage_idx/timeout_err; no further latency.
- IDLE:
  - fwd: select the lowest non-bypassed stage, go START, clear timeout_err.
  - All stages bypassed: stay IDLE.
  - bwd: ignored.
- START: lasts exactly 1 cycle, then unconditionally WAIT. stage_done is ignored in START.
- WAIT: evaluated in priority order.
  - bwd: abort to IDLE.
  - stage_done[stage_idx]: go HOLD.
  - watchdog expiry: go IDLE and set timeout_err.
  - Done bits of other stages are ignored.
  - Done and bwd in the same cycle: bwd wins.
  - Done and expiry in the same cycle: done wins.
- HOLD:
  - fwd: go START at the next non-bypassed stage with index greater than stage_idx.
  - No such stage: remain HOLD (final result displayed).
  - bwd: go IDLE.
- Bypass mask is sampled only at the cycle a stage is selected. Changing it mid-WAIT has no effect on the current stage.
- stage_idx is held through START/WAIT/HOLD and returns to 0 on entry to IDLE.
- Watchdog counter:
  - Cleared on WAIT entry; increments each WAIT cycle.
  - Expiry when count == TIMEOUT_CYCLES-1 (i.e. the TIMEOUT_CYCLES-th WAIT cycle).
  - Width $clog2(TIMEOUT_CYCLES); must never wrap before expiry.
- Unreachable encodings recover to IDLE.

Optional Feature:
- Macro: MAIN_SEQ_TIMEOUT_EN.
- Defined: watchdog counter and timeout_err behave as above.
- Undefined: no counter is instantiated; timeout_err is tied 0; WAIT exits only on done or bwd; TIMEOUT_CYCLES is ignored.

Decomposition:
- Package main_seq_pkg holds:
  - Phase encodings PH_IDLE/PH_START/PH_WAIT/PH_HOLD.
  - PHASE_W=2.
  - MAX_STAGES=8.
- Sub-module stage_pick: combinational priority finder. Given the bypass mask and a base index, it returns the lowest non-bypassed index ≥ base plus a valid flag. Used for both IDLE entry (base 0) and HOLD advance (base stage_idx+1).

Test Plan (NUM_STAGES=3, TIMEOUT_CYCLES=16):
- Basic sequence:
  - Stimulus: reset, switch=1, press enter.
  - Required: 1 cycle later phase=1, stage_start=3'b001 for one cycle, then phase=2.
  - Stimulus: stage_done[0].
  - Required: phase=3.
  - Stimulus: press twice more with done pulses between.
  - Required: stages 1, 2 visited; a further fwd leaves HOLD, stage_idx=2.
- Bypass and hold-button:
  - Stimulus: stage_bypass=3'b010, button held 20 cycles.
  - Required: single start on stage 0; after done and a fwd, start goes to stage 2 (stage_start=3'b100).
  - Stimulus: stage_bypass=3'b111, fwd.
  - Required: remains IDLE.
- Abort and done priority:
  - Stimulus: in WAIT, switch=0, press.
  - Required: IDLE next cycle, stage_idx=0.
  - Stimulus: bwd and stage_done coincide in WAIT.
  - Required: IDLE.
  - Stimulus: stage_done[1] while waiting on stage 0.
  - Required: ignored.
- Watchdog (macro defined):
  - Stimulus: no done for 16 WAIT cycles.
  - Required: IDLE, timeout_err=1; cleared by next fwd.
  - Stimulus: done on cycle 16.
  - Required: HOLD, timeout_err=0.
  - Macro undefined: 100 cycles without done leaves phase=2 and timeout_err=0.
- Reset mid-operation:
  - Stimulus: assert reset_n=0 asynchronously during START.
  - Required: stage_start=0 and phase=0 before the next clk edge.
  - Stimulus: release reset.
  - Required: IDLE, with no spurious press event from a button held through reset.

Source files
------------

// File: rtl/main_seq_pkg.sv
// Shared phase encodings and limits for the main_seq stage sequencer.
package main_seq_pkg;

  localparam int PHASE_W    = 2;
  localparam int MAX_STAGES = 8;

  typedef enum logic [PHASE_W-1:0] {
    PH_IDLE  = 2'd0,
    PH_START = 2'd1,
    PH_WAIT  = 2'd2,
    PH_HOLD  = 2'd3
  } phase_e;

endpackage

// File: rtl/main_seq_stage_pick.sv
// Combinational priority finder: lowest non-bypassed stage index >= base.
module stage_pick
  import main_seq_pkg::*;
#(
  parameter int N  = 3,
  parameter int SW = 2
) (
  input  logic [N-1:0]  bypass,
  input  logic [SW:0]   base,
  output logic [SW-1:0] idx,
  output logic          valid
);

  // Scan from the top down so the last hit is the lowest qualifying index.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!bypass[i] && ((SW+1)'(i) >= base)) begin
        idx   = SW'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/main_seq.sv
// Top-level stage sequencer: IDLE -> START -> WAIT -> HOLD per stage.
// Optional WAIT watchdog enabled by defining MAIN_SEQ_TIMEOUT_EN.
module main_seq
  import main_seq_pkg::*;
#(
  parameter int NUM_STAGES     = 3,
  parameter int TIMEOUT_CYCLES = 27000000,
  parameter int SW             = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  button_enter,
  input  logic                  switch,
  input  logic [NUM_STAGES-1:0] stage_bypass,
  input  logic [NUM_STAGES-1:0] stage_done,
  output logic [PHASE_W-1:0]    phase,
  output logic [SW-1:0]         stage_idx,
  output logic [NUM_STAGES-1:0] stage_start,
  output logic                  busy,
  output logic                  timeout_err
);

  if (NUM_STAGES < 1 || NUM_STAGES > MAX_STAGES || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("main_seq: parameter out of range");
  end

  phase_e        phase_q;
  logic [SW-1:0] idx_q;
  logic          terr_q;
  logic          btn_q;
  logic          press_q;
  logic          fwd;
  logic          bwd;
  logic          expire;
  logic [SW:0]   pick_base;
  logic [SW-1:0] pick_idx;
  logic          pick_vld;

  assign fwd = press_q & switch;
  assign bwd = press_q & ~switch;

  assign pick_base = (phase_q == PH_IDLE) ? '0 : ({1'b0, idx_q} + (SW+1)'(1));

  stage_pick #(
    .N  (NUM_STAGES),
    .SW (SW)
  ) u_pick (
    .bypass (stage_bypass),
    .base   (pick_base),
    .idx    (pick_idx),
    .valid  (pick_vld)
  );

`ifdef MAIN_SEQ_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TW-1:0] wd_q;

  assign expire = (wd_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_q <= '0;
    end else if (phase_q == PH_START) begin
      wd_q <= '0;
    end else if (phase_q == PH_WAIT && !expire) begin
      wd_q <= wd_q + TW'(1);
    end
  end
`else
  assign expire = 1'b0;
`endif

  // btn_q resets high so a button held through reset never registers a press.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q <= PH_IDLE;
      idx_q   <= '0;
      terr_q  <= 1'b0;
      btn_q   <= 1'b1;
      press_q <= 1'b0;
    end else begin
      btn_q   <= button_enter;
      press_q <= button_enter & ~btn_q;
      case (phase_q)
        PH_IDLE: begin
          if (fwd) begin
            terr_q <= 1'b0;
            if (pick_vld) begin
              phase_q <= PH_START;
              idx_q   <= pick_idx;
            end
          end
        end
        PH_START: phase_q <= PH_WAIT;
        PH_WAIT: begin
          if (bwd) begin
            phase_q <= PH_IDLE;
            idx_q   <= '0;
          end else if (stage_done[idx_q]) begin
            phase_q <= PH_HOLD;
          end else if (expire) begin
            phase_q <= PH_IDLE;
            idx_q   <= '0;
            terr_q  <= 1'b1;
          end
        end
        PH_HOLD: begin
          if (fwd && pick_vld) begin
            phase_q <= PH_START;
            idx_q   <= pick_idx;
          end else if (bwd) begin
            phase_q <= PH_IDLE;
            idx_q   <= '0;
          end
        end
        default: begin
          phase_q <= PH_IDLE;
          idx_q   <= '0;
        end
      endcase
    end
  end

  assign phase       = phase_q;
  assign stage_idx   = idx_q;
  assign stage_start = (phase_q == PH_START) ? (NUM_STAGES'(1) << idx_q) : '0;
  assign busy        = (phase_q == PH_START) || (phase_q == PH_WAIT);
  assign timeout_err = terr_q;

endmodule
